btn_conditioner: RTL and testbench

Conditions the three raw game push-buttons before they reach the Genius game FSM, which consumes only clean, single-cycle press events.
- Synchronizes btn_raw to the clock and debounces both press and release.
- Emits exactly one btn_pulse per physical press, plus a registered btn_code for the accepted button.
- Flags simultaneous multi-button presses separately so the FSM can treat them as a wrong choice.

---
 rtl/btn_conditioner_if.sv | 27 ++
 rtl/btn_conditioner.sv | 127 ++++++++++++
 tb/tb_btn_conditioner.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw buttons and enable in, clean press events out.
interface btn_conditioner_if;
  logic [2:0] btn_raw;
  logic       enable;
  logic [2:0] btn_pulse;
  logic [1:0] btn_code;
  logic       multi_press;
  logic       btn_held;

  modport master (
    output btn_raw,
    output enable,
    input  btn_pulse,
    input  btn_code,
    input  multi_press,
    input  btn_held
  );

  modport slave (
    input  btn_raw,
    input  enable,
    output btn_pulse,
    output btn_code,
    output multi_press,
    output btn_held
  );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronizes and debounces three raw push-buttons and turns each physical
// press into a single-cycle event (one-hot pulse or multi-press flag).
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  btn_conditioner_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  // A press pattern with exactly one button down.
  function automatic logic is_one_hot(input logic [2:0] p);
    return (p == 3'b001) || (p == 3'b010) || (p == 3'b100);
  endfunction

  // Index of a one-hot press pattern.
  function automatic logic [1:0] encode(input logic [2:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    if (p[1]) idx = 2'd1;
    if (p[2]) idx = 2'd2;
    return idx;
  endfunction

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [2:0]       pulse_q, pulse_d;
  logic [1:0]       code_q, code_d;
  logic             multi_q, multi_d;
  logic             held_q, held_d;

  // Next-state logic: synchronizer shift, debounce FSM and registered event outputs.
  always_comb begin
    sync1_d = bus.btn_raw;
    sync2_d = sync1_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    pulse_d = 3'b000;
    code_d  = code_q;
    multi_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q != 3'b000) begin
          pat_d   = sync2_q;
          cnt_d   = '0;
          state_d = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (sync2_q != pat_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          // enable only matters at the moment the press is accepted
          if (bus.enable) begin
            if (is_one_hot(pat_q)) begin
              pulse_d = pat_q;
              code_d  = encode(pat_q);
            end else begin
              multi_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        // pattern changes while held never re-trigger; only full release counts
        if (sync2_q == 3'b000) begin
          cnt_d   = '0;
          state_d = DEB_REL;
        end
      end
      DEB_REL: begin
        if (sync2_q != 3'b000) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d == HELD) || (state_d == DEB_REL);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      pat_q   <= 3'b000;
      cnt_q   <= '0;
      state_q <= IDLE;
      pulse_q <= 3'b000;
      code_q  <= 2'b00;
      multi_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pulse_q <= pulse_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      held_q  <= held_d;
    end
  end

  assign bus.btn_pulse   = pulse_q;
  assign bus.btn_code    = code_q;
  assign bus.multi_press = multi_q;
  assign bus.btn_held    = held_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner: directed scenarios plus randomized button
// activity, compared every cycle against a run-length reference model.
module tb_btn_conditioner;

  localparam int D = 4;

  logic clock;
  logic reset;

  btn_conditioner_if bif ();

  btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [2:0] m_s1, m_s2, m_pat;
  bit         m_released;
  int         m_run;
  logic [2:0] e_pulse;
  logic [1:0] e_code;
  logic       e_multi;

  // bookkeeping for directed checks
  int cyc_n = 0;
  int n_pulse, n_multi, last_pulse;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 3'b000; m_s2 = 3'b000; m_pat = 3'b000;
    m_released = 1'b1; m_run = 0;
    e_pulse = 3'b000; e_code = 2'b00; e_multi = 1'b0;
  endtask

  // One clock edge of the model: a press is accepted after D+1 consecutive
  // identical nonzero synchronized samples while released; release completes
  // after D+1 consecutive zero samples while held.
  task automatic model_edge(input logic [2:0] raw, input logic en);
    logic [2:0] v;
    v    = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    e_pulse = 3'b000;
    e_multi = 1'b0;
    if (m_released) begin
      if (v == 3'b000) begin
        m_run = 0;
      end else if (m_run == 0) begin
        m_pat = v;
        m_run = 1;
      end else if (v != m_pat) begin
        m_run = 0;  // a jump to another pattern abandons the candidate
      end else begin
        m_run++;
        if (m_run == D + 1) begin
          m_released = 1'b0;
          m_run = 0;
          if (en) begin
            if ($countones(m_pat) == 1) begin
              e_pulse = m_pat;
              e_code  = (m_pat == 3'b001) ? 2'd0 : (m_pat == 3'b010) ? 2'd1 : 2'd2;
            end else begin
              e_multi = 1'b1;
            end
          end
        end
      end
    end else begin
      if (v != 3'b000) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == D + 1) begin
          m_released = 1'b1;
          m_run = 0;
        end
      end
    end
  endtask

  // Called at a negedge: drive inputs, take one edge, compare, return at the next negedge.
  task automatic cyc(input logic [2:0] raw, input logic en);
    bif.btn_raw = raw;
    bif.enable  = en;
    @(posedge clock);
    cyc_n++;
    model_edge(raw, en);
    #1;
    check_val("btn_pulse", {5'b0, bif.btn_pulse}, {5'b0, e_pulse});
    check_val("btn_code", {6'b0, bif.btn_code}, {6'b0, e_code});
    check_val("multi_press", {7'b0, bif.multi_press}, {7'b0, e_multi});
    check_val("btn_held", {7'b0, bif.btn_held}, {7'b0, !m_released});
    if (bif.btn_pulse != 3'b000) begin
      n_pulse++;
      last_pulse = cyc_n;
    end
    if (bif.multi_press) n_multi++;
    @(negedge clock);
  endtask

  // Called at a negedge: assert reset between edges, verify outputs clear at once.
  task automatic do_reset(input int n, input logic [2:0] raw);
    bif.btn_raw = raw;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_pulse", {5'b0, bif.btn_pulse}, 8'd0);
    check_val("rst_code", {6'b0, bif.btn_code}, 8'd0);
    check_val("rst_multi", {7'b0, bif.multi_press}, 8'd0);
    check_val("rst_held", {7'b0, bif.btn_held}, 8'd0);
    repeat (n) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic clear_counts();
    n_pulse = 0;
    n_multi = 0;
    last_pulse = -1;
  endtask

  initial begin
    int c0;
    logic [2:0] v;
    logic en;
    int r, dur;

    reset = 1'b0;
    bif.btn_raw = 3'b000;
    bif.enable  = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    check_val("init_pulse", {5'b0, bif.btn_pulse}, 8'd0);
    check_val("init_code", {6'b0, bif.btn_code}, 8'd0);
    check_val("init_multi", {7'b0, bif.multi_press}, 8'd0);
    check_val("init_held", {7'b0, bif.btn_held}, 8'd0);
    reset = 1'b1;
    repeat (3) cyc(3'b000, 1'b1);

    // clean single press of button 1
    clear_counts();
    c0 = cyc_n + 1;
    repeat (20) cyc(3'b010, 1'b1);
    repeat (12) cyc(3'b000, 1'b1);
    check_val("t1_npulse", 8'(n_pulse), 8'd1);
    check_val("t1_latency", 8'(last_pulse - c0), 8'd6);
    check_val("t1_code", {6'b0, bif.btn_code}, 8'd1);

    // bouncy press of button 0
    clear_counts();
    for (int k = 0; k < 12; k++) cyc(((k / 2) % 2 == 0) ? 3'b001 : 3'b000, 1'b1);
    c0 = cyc_n + 1;
    repeat (10) cyc(3'b001, 1'b1);
    repeat (12) cyc(3'b000, 1'b1);
    check_val("t2_npulse", 8'(n_pulse), 8'd1);
    check_val("t2_latency", 8'(last_pulse - c0), 8'd6);
    check_val("t2_code", {6'b0, bif.btn_code}, 8'd0);

    // simultaneous buttons 0 and 2
    clear_counts();
    repeat (10) cyc(3'b101, 1'b1);
    repeat (12) cyc(3'b000, 1'b1);
    check_val("t3_nmulti", 8'(n_multi), 8'd1);
    check_val("t3_npulse", 8'(n_pulse), 8'd0);
    check_val("t3_code", {6'b0, bif.btn_code}, 8'd0);

    // disabled press, then enabled press of button 2
    clear_counts();
    repeat (10) cyc(3'b100, 1'b0);
    repeat (12) cyc(3'b000, 1'b0);
    check_val("t4_disabled", 8'(n_pulse), 8'd0);
    repeat (10) cyc(3'b100, 1'b1);
    repeat (12) cyc(3'b000, 1'b1);
    check_val("t4_npulse", 8'(n_pulse), 8'd1);
    check_val("t4_code", {6'b0, bif.btn_code}, 8'd2);

    // reset in the middle of a debounce, button kept down
    clear_counts();
    repeat (3) cyc(3'b001, 1'b1);
    do_reset(2, 3'b001);
    c0 = cyc_n + 1;
    repeat (10) cyc(3'b001, 1'b1);
    repeat (12) cyc(3'b000, 1'b1);
    check_val("t5_npulse", 8'(n_pulse), 8'd1);
    check_val("t5_latency", 8'(last_pulse - c0), 8'd6);

    // short release glitch while held
    clear_counts();
    repeat (10) cyc(3'b010, 1'b1);
    repeat (2) cyc(3'b000, 1'b1);
    repeat (6) cyc(3'b010, 1'b1);
    check_val("t6_held", {7'b0, bif.btn_held}, 8'd1);
    repeat (12) cyc(3'b000, 1'b1);
    check_val("t6_npulse", 8'(n_pulse), 8'd1);

    // randomized activity with occasional resets and enable changes
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      v = 3'b000;
      else if (r < 8) v = 3'b001 << $urandom_range(0, 2);
      else            v = 3'($urandom_range(1, 7));
      en  = ($urandom_range(0, 7) != 0);
      dur = $urandom_range(1, 12);
      if ($urandom_range(0, 60) == 0) do_reset($urandom_range(1, 3), v);
      repeat (dur) cyc(v, en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
